// File: rtl/sram_stream_adapter.sv
// sram_stream_adapter
//
// Valid/ready front end for one port of a single-cycle-issue SRAM macro.
// Requests are passed straight through to the macro port. Read data is
// captured Latency cycles after issue and queued in an in-order response
// FIFO. A credit counter makes sure each issued read already owns a FIFO
// slot, so read data returning from the macro is never dropped.
//
// Handshake semantics (both channels): a transfer happens on the rising
// edge where valid and ready are both high. Valid must not wait on ready.
// req_ready_o depends only on state and reset, never on req_valid_i,
// req_we_i or rsp_ready_i.
//
// Ports
//   clk_i        in   clock, all state on the rising edge
//   rst_i        in   synchronous reset, active-high
//   req_valid_i  in   request valid
//   req_ready_o  out  request accepted when valid & ready
//   req_we_i     in   1 = write, 0 = read
//   req_addr_i   in   word address
//   req_wdata_i  in   write data
//   req_be_i     in   write byte enables
//   rsp_valid_o  out  read response valid
//   rsp_ready_i  in   response consumed when valid & ready
//   rsp_rdata_o  out  read data (0 when no response is pending)
//   mem_req_o    out  macro request
//   mem_we_o     out  macro write enable
//   mem_addr_o   out  macro address
//   mem_wdata_o  out  macro write data
//   mem_be_o     out  macro byte enables (0 on reads)
//   mem_rdata_i  in   macro read data, valid Latency cycles after a read
module sram_stream_adapter #(
    parameter int AddrWidth = 10,
    parameter int DataWidth = 32,
    parameter int ByteWidth = 8,
    parameter int Latency   = 1,
    parameter int RspDepth  = 2,
    localparam int BeWidth  = (DataWidth + ByteWidth - 1) / ByteWidth,
    localparam int CntWidth = $clog2(RspDepth + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [DataWidth-1:0] req_wdata_i,
    input  logic [BeWidth-1:0]   req_be_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_rdata_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [DataWidth-1:0] mem_wdata_o,
    output logic [BeWidth-1:0]   mem_be_o,
    input  logic [DataWidth-1:0] mem_rdata_i
);

    localparam int PtrWidth = (RspDepth > 1) ? $clog2(RspDepth) : 1;

    // Reads issued but not yet popped, wherever they currently are.
    logic [CntWidth-1:0]  outstanding_q;
    // One bit per read in flight inside the macro; bit 0 means data is on
    // mem_rdata_i this cycle.
    logic [Latency-1:0]   rd_pipe_q;

    logic [DataWidth-1:0] fifo_q [RspDepth];
    logic [PtrWidth-1:0]  wr_ptr_q;
    logic [PtrWidth-1:0]  rd_ptr_q;
    logic [CntWidth-1:0]  count_q;

    logic req_hs;
    logic rd_hs;
    logic push;
    logic pop;
    logic fifo_full;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(RspDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credits only: keeping this free of req_valid_i avoids a
    // combinational valid-to-ready loop with the requester.
    assign req_ready_o = !rst_i && (outstanding_q < CntWidth'(RspDepth));
    assign req_hs      = req_valid_i & req_ready_o;
    assign rd_hs       = req_hs & ~req_we_i;

    assign mem_req_o   = req_hs;
    assign mem_we_o    = req_we_i;
    assign mem_addr_o  = req_addr_i;
    assign mem_wdata_o = req_wdata_i;
    assign mem_be_o    = req_we_i ? req_be_i : '0;

    assign push        = rd_pipe_q[0] & ~rst_i;
    assign fifo_full   = (count_q == CntWidth'(RspDepth));
    assign rsp_valid_o = !rst_i && (count_q != '0);
    assign pop         = rsp_valid_o & rsp_ready_i;
    assign rsp_rdata_o = rsp_valid_o ? fifo_q[rd_ptr_q] : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outstanding_q <= '0;
        end else begin
            case ({rd_hs, pop})
                2'b10:   outstanding_q <= outstanding_q + 1'b1;
                2'b01:   outstanding_q <= outstanding_q - 1'b1;
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_pipe_q <= '0;
        end else begin
            rd_pipe_q[Latency-1] <= rd_hs;
            for (int i = 0; i < Latency - 1; i++) begin
                rd_pipe_q[i] <= rd_pipe_q[i+1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= mem_rdata_i;
        end
    end

    // The credit scheme should make this unreachable; a simultaneous pop
    // frees the slot being overwritten, so that case is legal.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(push && fifo_full && !pop));
        end
    end

endmodule

// File: tb/tb_sram_stream_adapter.sv
module tb_sram_stream_adapter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BW = 4;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT 1: Latency 1, RspDepth 2 ----------------
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [BW-1:0] req_be;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [BW-1:0] mem_be;
    logic [DW-1:0] mem_rdata;

    sram_stream_adapter #(.Latency(1), .RspDepth(2)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_rdata_i(mem_rdata)
    );

    // Behavioural macro, read latency 1. Contents survive reset.
    logic [DW-1:0] mem1 [1024];
    always @(posedge clk) begin
        if (mem_req) begin
            if (mem_we) begin
                for (int b = 0; b < BW; b++)
                    if (mem_be[b]) mem1[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end else begin
                mem_rdata <= mem1[mem_addr];
            end
        end
    end

    // ---------------- DUT 2: Latency 2, streaming ----------------
    // A credit is held from the handshake cycle until the pop, i.e. for
    // Latency+2 cycles, so a gapless stream needs RspDepth = Latency+2.
    logic          req_valid2, req_ready2;
    logic [AW-1:0] req_addr2;
    logic          rsp_valid2;
    logic [DW-1:0] rsp_rdata2;
    logic          mem_req2, mem_we2;
    logic [AW-1:0] mem_addr2;
    logic [DW-1:0] mem_wdata2;
    logic [BW-1:0] mem_be2;
    logic [DW-1:0] mem2_s1, mem2_s2;
    logic          req_we2   = 1'b0;
    logic [DW-1:0] req_wdata2 = '0;
    logic [BW-1:0] req_be2   = '0;
    logic          rsp_ready2 = 1'b1;

    sram_stream_adapter #(.Latency(2), .RspDepth(4)) dut2 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid2), .req_ready_o(req_ready2), .req_we_i(req_we2),
        .req_addr_i(req_addr2), .req_wdata_i(req_wdata2), .req_be_i(req_be2),
        .rsp_valid_o(rsp_valid2), .rsp_ready_i(rsp_ready2), .rsp_rdata_o(rsp_rdata2),
        .mem_req_o(mem_req2), .mem_we_o(mem_we2), .mem_addr_o(mem_addr2),
        .mem_wdata_o(mem_wdata2), .mem_be_o(mem_be2), .mem_rdata_i(mem2_s2)
    );

    // Read-only macro for the stream: data is a fixed function of address.
    function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
        return 32'hA5A5_0000 | {22'h0, a};
    endfunction

    always @(posedge clk) begin
        if (mem_req2) mem2_s1 <= rom(mem_addr2);
        mem2_s2 <= mem2_s1;
    end

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp2_q[$];
    int            exp2_cyc_q[$];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) check("unexpected_rsp", 32'd1, 32'd0);
            else check("rsp_data", rsp_rdata, exp_q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (rsp_valid2 && rsp_ready2) begin
            if (exp2_q.size() == 0) begin
                check("unexpected_rsp2", 32'd1, 32'd0);
            end else begin
                check("stream_data", rsp_rdata2, exp2_q.pop_front());
                check("stream_cycle", cyc, exp2_cyc_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Presents one request on DUT 1 and holds it until accepted. Entered
    // and left just after a rising edge.
    task automatic send(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input logic [BW-1:0] be, input logic [DW-1:0] exp, output int hs);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
        hs = -1;
        for (int i = 0; i < 40 && hs < 0; i++) begin
            @(negedge clk);
            if (req_ready) begin
                hs = cyc;
                check("mem_req", 32'(mem_req), 32'd1);
                check("mem_we", 32'(mem_we), 32'(we));
                check("mem_addr", 32'(mem_addr), 32'(addr));
                check("mem_be", 32'(mem_be), we ? 32'(be) : 32'd0);
                if (we) check("mem_wdata", mem_wdata, wd);
                else exp_q.push_back(exp);
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        if (hs < 0) check("handshake_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0 && exp2_q.size() == 0) break;
            @(posedge clk); #1;
        end
        check("drain", 32'(exp_q.size() + exp2_q.size()), 32'd0);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [BW-1:0] be;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int hs;

        vecs[0] = '{1'b1, 10'h010, 32'h1122_3344, 4'hF, 32'h0};
        vecs[1] = '{1'b1, 10'h010, 32'hAABB_CCDD, 4'h5, 32'h0};
        vecs[2] = '{1'b0, 10'h010, 32'h0,         4'hF, 32'h11BB_33DD};
        vecs[3] = '{1'b1, 10'h3FF, 32'hFFFF_FFFF, 4'hF, 32'h0};
        vecs[4] = '{1'b1, 10'h3FF, 32'h0000_0000, 4'h3, 32'h0};
        vecs[5] = '{1'b0, 10'h3FF, 32'h0,         4'hF, 32'hFFFF_0000};
        vecs[6] = '{1'b1, 10'h020, 32'hCAFE_F00D, 4'hF, 32'h0};
        vecs[7] = '{1'b1, 10'h020, 32'h1234_5678, 4'hA, 32'h0};
        vecs[8] = '{1'b0, 10'h020, 32'h0,         4'hF, 32'h12FE_560D};
        vecs[9] = '{1'b0, 10'h005, 32'h0,         4'hF, 32'hDEAD_BEEF};

        // Reset, with a request held valid to show nothing issues.
        rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h3FF;
        req_wdata = '0; req_be = 4'hF; rsp_ready = 1'b1;
        req_valid2 = 1'b0; req_addr2 = '0;
        repeat (2) begin
            @(negedge clk);
            check("rst_req_ready", 32'(req_ready), 32'd0);
            check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            check("rst_rsp_rdata", rsp_rdata, 32'd0);
            check("rst_mem_req", 32'(mem_req), 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", 32'(req_ready), 32'd1);
        check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_rst_rsp_rdata", rsp_rdata, 32'd0);
        check("post_rst_outstanding", 32'(dut.outstanding_q), 32'd0);
        @(posedge clk); #1;

        // Write then read: response valid exactly two cycles after handshake.
        send(1'b1, 10'h005, 32'hDEAD_BEEF, 4'hF, 32'h0, hs);
        send(1'b0, 10'h005, 32'h0, 4'hF, 32'hDEAD_BEEF, hs);
        @(negedge clk);
        check("lat_c1_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("lat_c2_valid", 32'(rsp_valid), 32'd1);
        check("lat_c2_data", rsp_rdata, 32'hDEAD_BEEF);
        @(negedge clk);
        check("lat_c3_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;

        // Table of writes / partial writes / reads.
        for (int i = 0; i < 10; i++)
            send(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].exp, hs);
        wait_idle();

        // Backpressure: only two reads fit while responses are held.
        for (int i = 1; i <= 4; i++)
            send(1'b1, AW'(i), 32'h100 + i, 4'hF, 32'h0, hs);
        rsp_ready = 1'b0;
        send(1'b0, 10'h001, 32'h0, 4'hF, 32'h101, hs);
        send(1'b0, 10'h002, 32'h0, 4'hF, 32'h102, hs);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h003;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("bp_ready_low", 32'(req_ready), 32'd0);
            check("bp_mem_req", 32'(mem_req), 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("bp_head_valid", 32'(rsp_valid), 32'd1);
        check("bp_head_data", rsp_rdata, 32'h101);
        @(posedge clk); #1;
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_before_pop", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_credit_return", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        send(1'b0, 10'h003, 32'h0, 4'hF, 32'h103, hs);
        send(1'b0, 10'h004, 32'h0, 4'hF, 32'h104, hs);
        wait_idle();

        // Push and pop in the same cycle with one entry held.
        send(1'b0, 10'h005, 32'h0, 4'hF, 32'hDEAD_BEEF, hs);
        send(1'b0, 10'h010, 32'h0, 4'hF, 32'h11BB_33DD, hs);
        @(negedge clk);
        check("pp_count_a", 32'(dut.count_q), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("pp_count_b", 32'(dut.count_q), 32'd1);
        check("pp_head", rsp_rdata, 32'h11BB_33DD);
        @(posedge clk); #1;
        wait_idle();

        // Reset with two reads in flight.
        rsp_ready = 1'b0;
        send(1'b0, 10'h005, 32'h0, 4'hF, 32'hDEAD_BEEF, hs);
        send(1'b0, 10'h010, 32'h0, 4'hF, 32'h11BB_33DD, hs);
        rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h3FF;
        @(negedge clk);
        check("mrst_req_ready", 32'(req_ready), 32'd0);
        check("mrst_mem_req", 32'(mem_req), 32'd0);
        check("mrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mrst_rsp_rdata", rsp_rdata, 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        check("mrst_after_ready", 32'(req_ready), 32'd1);
        check("mrst_after_outstanding", 32'(dut.outstanding_q), 32'd0);
        for (int k = 0; k < 4; k++) begin
            check("mrst_no_rsp", 32'(rsp_valid), 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        send(1'b0, 10'h005, 32'h0, 4'hF, 32'hDEAD_BEEF, hs);
        wait_idle();

        // Streaming on DUT 2: 16 back-to-back reads.
        for (int k = 0; k < 16; k++) begin
            req_valid2 = 1'b1; req_addr2 = AW'(k * 3);
            @(negedge clk);
            check("stream_ready", 32'(req_ready2), 32'd1);
            if (req_ready2) begin
                exp2_q.push_back(rom(AW'(k * 3)));
                exp2_cyc_q.push_back(cyc + 3);
            end
            @(posedge clk); #1;
        end
        req_valid2 = 1'b0;
        wait_idle();

        check("final_queues", 32'(exp_q.size() + exp2_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
